// File: rtl/fetch_pkg.sv
// Shared types and constants for the Thumb fetch unit: FSM states, halfword
// and FIFO entry types, and the address masks.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef logic [15:0] hword_t;

   typedef struct packed {
      hword_t      instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] HW_MASK   = 32'hFFFF_FFFE;

endpackage

// File: rtl/fetch_hw_fifo.sv
// Prefetch FIFO of halfword instructions: accepts 0/1/2 entries per cycle,
// pops one, synchronous flush, and reports its free slot count.
module fetch_hw_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int unsigned PW      = $clog2(DEPTH),
   localparam int unsigned CW      = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic [1:0]    push_n_i,
   input  fetch_entry_t  push0_i,
   input  fetch_entry_t  push1_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic          valid_o,
   output logic [CW-1:0] free_o
);

   localparam fetch_entry_t RST_ENTRY = '{instr: '0, pc: RESET_PC & HW_MASK};

   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   fetch_entry_t  mem_q [DEPTH];
   logic          do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign valid_o = (cnt_q != '0);
   assign free_o  = CW'(DEPTH) - cnt_q;
   assign head_o  = mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_n_i != 2'd0) mem_q[wr_q] <= push0_i;
         if (push_n_i == 2'd2) mem_q[wr_q + PW'(1)] <= push1_i;
         wr_q  <= wr_q + PW'(push_n_i);
         rd_q  <= rd_q + PW'(do_pop);
         cnt_q <= cnt_q + CW'(push_n_i) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/thumb_fetch.sv
// Thumb instruction fetch: word reads split into halfwords, prefetch FIFO,
// branch redirect. Optional FETCH_PERF_EN adds perf_words/perf_flushes counters.
module thumb_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_words,
   output logic [31:0] perf_flushes
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;

   fetch_entry_t  lo_e, hi_e, push0, push1, head;
   logic [1:0]    push_n;
   logic [CW-1:0] free;
   logic [CW-1:0] need;
   logic [31:0]   br_pc;

   assign br_pc = branch_target & HW_MASK;
   assign need  = fetch_pc_q[1] ? CW'(1) : CW'(2);
   assign lo_e  = '{instr: mem_rdata[15:0],  pc: addr_q};
   assign hi_e  = '{instr: mem_rdata[31:16], pc: addr_q + 32'd2};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      push_n     = 2'd0;
      push0      = lo_e;
      push1      = hi_e;
      case (state_q)
         IDLE: begin
            // A redirect empties the FIFO, so it can be fetched from right away.
            if (branch_valid) begin
               fetch_pc_d = br_pc;
               req_d      = 1'b1;
               addr_d     = branch_target & WORD_MASK;
               state_d    = WAIT;
            end else if (free >= need) begin
               req_d   = 1'b1;
               addr_d  = fetch_pc_q & WORD_MASK;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (branch_valid) begin
               fetch_pc_d = br_pc;
               if (mem_ack) begin
                  req_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = DROP;
               end
            end else if (mem_ack) begin
               req_d      = 1'b0;
               state_d    = IDLE;
               fetch_pc_d = addr_q + 32'd4;
               if (fetch_pc_q[1]) begin
                  push_n = 2'd1;
                  push0  = hi_e;
               end else begin
                  push_n = 2'd2;
               end
            end
         end
         DROP: begin
            if (branch_valid) fetch_pc_d = br_pc;
            if (mem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC & HW_MASK;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC & WORD_MASK;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   fetch_hw_fifo #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (branch_valid),
      .push_n_i (push_n),
      .push0_i  (push0),
      .push1_i  (push1),
      .pop_i    (instr_valid && instr_ready),
      .head_o   (head),
      .valid_o  (instr_valid),
      .free_o   (free)
   );

   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign instr    = head.instr;
   assign instr_pc = head.pc;

`ifdef FETCH_PERF_EN
   logic [31:0] words_q, flushes_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_q   <= '0;
         flushes_q <= '0;
      end else begin
         if (req_q && mem_ack) words_q <= words_q + 32'd1;
         if (branch_valid) flushes_q <= flushes_q + 32'd1;
      end
   end

   assign perf_words   = words_q;
   assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_thumb_fetch.sv
// Bench for thumb_fetch: directed scenarios plus random traffic checked every
// cycle against a queue-based model of the fetched instruction stream.
module tb_thumb_fetch;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk, rst_n;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_rdata;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        instr_valid, instr_ready;
   logic [15:0] instr;
   logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_words, perf_flushes;
`endif

   thumb_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_words    (perf_words),
      .perf_flushes  (perf_flushes)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory image: word 0 is pinned, everything else is a fixed hash of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'd0) return 32'h1C49_1808;
      return {a[31:16] ^ a[15:0] ^ 16'h1357, a[15:0] ^ 16'hC3A5};
   endfunction

   function automatic logic [15:0] hw(input logic [31:0] pc);
      logic [31:0] w;
      w = memf({pc[31:2], 2'b00});
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   // Memory responder: ack after 'lat' cycles of a held request.
   int unsigned lat = 1;
   int unsigned cnt = 0;
   always @(posedge clk) begin
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) cnt = lat;
      else if (cnt == 0) begin
         mem_ack   = 1'b1;
         mem_rdata = memf(mem_addr);
      end else cnt--;
   end

   // Reference model: expected FIFO contents, next fetch address, outstanding read.
   typedef struct {
      logic [31:0] pc;
      logic [15:0] ins;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_fetch, m_addr, tgt;
   bit          m_out, m_drop, ack, was_out;
   int          free;
   logic [31:0] m_words, m_flush;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_fetch = RESET_PC & 32'hFFFF_FFFE;
         m_addr  = RESET_PC & 32'hFFFF_FFFC;
         m_out   = 1'b0;
         m_drop  = 1'b0;
         m_words = '0;
         m_flush = '0;
      end else begin
         chk("valid", 32'(instr_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
         if (mq.size() > 0) begin
            chk("instr", 32'(instr), 32'(mq[0].ins));
            chk("instr_pc", instr_pc, mq[0].pc);
         end
         chk("mem_req", 32'(mem_req), 32'(m_out));
         if (m_out) chk("mem_addr", mem_addr, m_addr);
`ifdef FETCH_PERF_EN
         chk("perf_words", perf_words, m_words);
         chk("perf_flushes", perf_flushes, m_flush);
`endif
         was_out = m_out;
         ack     = mem_ack && m_out;
         free    = DEPTH - mq.size();
         if (ack) m_words = m_words + 1;
         if (branch_valid) begin
            m_flush = m_flush + 1;
            mq.delete();
            tgt     = branch_target & 32'hFFFF_FFFE;
            m_fetch = tgt;
            if (!was_out) begin
               m_out  = 1'b1;
               m_drop = 1'b0;
               m_addr = {tgt[31:2], 2'b00};
            end else if (ack) begin
               m_out  = 1'b0;
               m_drop = 1'b0;
            end else m_drop = 1'b1;
         end else begin
            if (instr_ready && mq.size() > 0) void'(mq.pop_front());
            if (ack) begin
               if (!m_drop) begin
                  if (!m_fetch[1]) mq.push_back('{pc: m_addr, ins: hw(m_addr)});
                  mq.push_back('{pc: m_addr + 32'd2, ins: hw(m_addr + 32'd2)});
                  m_fetch = m_addr + 32'd4;
               end
               m_out  = 1'b0;
               m_drop = 1'b0;
            end else if (!was_out && free >= (m_fetch[1] ? 1 : 2)) begin
               m_out  = 1'b1;
               m_addr = {m_fetch[31:2], 2'b00};
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [31:0] exp_pc [4];
   logic [31:0] exp_in [4];

   initial begin
      rst_n = 1'b1; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h2; exp_pc[2] = 32'h4; exp_pc[3] = 32'h6;
      exp_in[0] = 32'h1808; exp_in[1] = 32'h1C49; exp_in[2] = 32'hC3A1; exp_in[3] = 32'h1353;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, RESET_PC & 32'hFFFF_FFFC);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", instr_pc, RESET_PC & 32'hFFFF_FFFE);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // 1: first word, ack after one cycle, decode always ready
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && !instr_valid; i++) step();
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr0", 32'(instr), 32'h1808);
      chk("t1_pc0", instr_pc, 32'h0);
      step();
      chk("t1_instr1", 32'(instr), 32'h1C49);
      chk("t1_pc1", instr_pc, 32'h2);

      // 2: decode stalled, immediate acks fill the FIFO then drain in order
      instr_ready = 1'b0;
      lat = 0;
      do_reset();
      repeat (12) step();
      chk("t2_req_idle", 32'(mem_req), 32'd0);
      chk("t2_valid", 32'(instr_valid), 32'd1);
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t2_drain_instr", 32'(instr), exp_in[k]);
         chk("t2_drain_pc", instr_pc, exp_pc[k]);
         step();
      end

      // 3: branch to a halfword-aligned target
      instr_ready = 1'b0;
      lat = 1;
      repeat (12) step();
      branch_valid = 1'b1; branch_target = 32'h0000_0102;
      step();
      branch_valid = 1'b0;
      chk("t3_req", 32'(mem_req), 32'd1);
      chk("t3_addr", mem_addr, 32'h100);
      chk("t3_flushed", 32'(instr_valid), 32'd0);
      step();
      lat = 3;
      step();
      chk("t3_valid", 32'(instr_valid), 32'd1);
      chk("t3_pc", instr_pc, 32'h102);
      chk("t3_instr", 32'(instr), 32'h1257);
      chk("t3_bubble", 32'(mem_req), 32'd0);
      instr_ready = 1'b1;
      step();
      chk("t3_next_addr", mem_addr, 32'h104);

      // 4: branch while a slow read is outstanding
      step();
      branch_valid = 1'b1; branch_target = 32'h0000_0200;
      step();
      branch_valid = 1'b0;
      chk("t4_req_held", 32'(mem_req), 32'd1);
      chk("t4_addr_held", mem_addr, 32'h104);
      step();
      step();
      chk("t4_no_stale", 32'(instr_valid), 32'd0);
      chk("t4_idle", 32'(mem_req), 32'd0);
      step();
      chk("t4_new_addr", mem_addr, 32'h200);

      // 5: branch together with ack and pop
      instr_ready = 1'b0;
      for (int i = 0; i < 30 && !(mem_ack && instr_valid); i++) step();
      chk("t5_sync", {30'd0, mem_ack, instr_valid}, 32'd3);
      branch_valid = 1'b1; branch_target = 32'h0000_0300; instr_ready = 1'b1;
      step();
      branch_valid = 1'b0;
      chk("t5_valid", 32'(instr_valid), 32'd0);
      step();
      chk("t5_req", 32'(mem_req), 32'd1);
      chk("t5_addr", mem_addr, 32'h300);

      // 6: asynchronous reset during an outstanding read
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("t6_req", 32'(mem_req), 32'd0);
      chk("t6_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
      chk("t6_perf_words", perf_words, 32'd0);
      chk("t6_perf_flushes", perf_flushes, 32'd0);
`endif
      step();
      step();
      rst_n = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;

      // random traffic, including targets near the top of the address space
      for (int c = 0; c < 3000; c++) begin
         step();
         lat          = $urandom_range(0, 3);
         instr_ready  = ($urandom_range(0, 3) != 0);
         branch_valid = ($urandom_range(0, 15) == 0);
         branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_0FFF);
      end
      branch_valid = 1'b0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
